// File: rtl/push_btn_bank.sv
// Bank of debounced push buttons driven by a tiny instruction set.
// Each pin is synchronised and debounced; rising stable levels latch until read.
module push_btn_bank #(
  parameter int Count        = 4,
  parameter int DebounceWait = 40000,
  parameter int DebounceSize = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      inst,
  input  logic             inst_en,
  input  logic [Count-1:0] buttons,
  output logic [Count-1:0] button_status,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RBS = 4'h1;
  localparam logic [3:0] OP_RBL = 4'h2;
  localparam logic [3:0] OP_SMK = 4'h3;
  localparam logic [3:0] OP_CLR = 4'h4;

  localparam logic [DebounceSize-1:0] WaitLast = DebounceSize'(DebounceWait - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [Count-1:0]        sync_a_q, sync_b_q;
  logic [Count-1:0]        stable_q;
  logic [DebounceSize-1:0] cnt_q [Count];
  logic [Count-1:0]        press_evt;
  logic [Count-1:0]        press_live;

  logic [Count-1:0] status_q, status_d;
  logic [Count-1:0] pressed_q, pressed_d;
  logic [Count-1:0] mask_q, mask_d;

  logic [3:0]       opcode;
  logic [Count-1:0] imm_mask;
  logic [7:0]       unused_imm;

  assign opcode     = inst[11:8];
  assign imm_mask   = inst[Count-1:0];
  assign unused_imm = inst[7:0];

  // Debounce keeps running in every FSM state; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      stable_q <= '0;
      for (int i = 0; i < Count; i++) cnt_q[i] <= '0;
    end else begin
      sync_a_q <= buttons;
      sync_b_q <= sync_a_q;
      for (int i = 0; i < Count; i++) begin
        if (sync_b_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == WaitLast) begin
          stable_q[i] <= ~stable_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DebounceSize'(1);
        end
      end
    end
  end

  // The press event is asserted in the cycle whose closing edge flips stable 0->1.
  always_comb begin
    press_evt = '0;
    for (int i = 0; i < Count; i++) begin
      press_evt[i] = (sync_b_q[i] != stable_q[i]) && (cnt_q[i] == WaitLast) && !stable_q[i];
    end
  end

  assign press_live = press_evt & ~mask_q;

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    pressed_d = pressed_q;
    mask_d    = mask_q;
    case (state_q)
      ST_RESET: state_d = ST_READY;
      ST_READY: begin
        pressed_d = pressed_q | press_live;
        if (inst_en) begin
          case (opcode)
            OP_NOP: ;
            OP_RBS: begin
              status_d  = pressed_q;
              pressed_d = press_live;
            end
            OP_RBL: status_d = stable_q;
            OP_SMK: begin
              // Same-cycle events already passed the old mask via press_live.
              mask_d    = imm_mask;
              pressed_d = (pressed_q | press_live) & ~imm_mask;
            end
            OP_CLR: pressed_d = press_live;
            default: begin
              state_d   = ST_ERROR;
              status_d  = '0;
              pressed_d = '0;
              mask_d    = '0;
            end
          endcase
        end
      end
      ST_ERROR: begin
        status_d  = '0;
        pressed_d = '0;
        mask_d    = '0;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RESET;
      status_q  <= '0;
      pressed_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      pressed_q <= pressed_d;
      mask_q    <= mask_d;
    end
  end

  assign button_status = status_q;
  assign state_dbg     = state_q;

endmodule
